spi_flash_reader: RTL
=====================

# spi_flash_reader

Wishbone master that sequences the `wb_spi` peripheral to perform SPI-flash READ (0x03) transactions. Given a 24-bit flash address and a byte count, it:

- asserts chip-select;
- pushes the command and address through the TX FIFO;
- discards the header echo bytes;
- clocks out the requested data in bounded chunks, streaming each received byte to a valid/ready consumer;
- releases chip-select.

It sits between a boot/loader client and the `wb_spi` slave port, sharing its clock and reset.

## Interface
- `CHUNK`, 16: max dummy bytes in flight per burst; must be ≤ the `wb_spi` FIFO depth, range 1..64.
- `CMD`, 8'h03: flash read opcode.

- `clk_i`  in  1  system clock; everything is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `addr`  in  24  flash byte address; captured on `start`.
- `len`  in  16  byte count; captured on `start`; 0 is legal.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the transfer completes and SS is released.
- `out_data`  out  8  received flash byte.
- `out_valid`  out  1  `out_data` valid; held until `out_ready`.
- `out_ready`  in  1  consumer accepts on `out_valid & out_ready`.
- `m_cyc_o`, `m_stb_o`  out  1  bus request; the two are always equal.
- `m_adr_o`  out  2  0 = data register, 1 = status/control register.
- `m_we_o`  out  1  write enable.
- `m_dat_o`  out  32  write data; the byte is in [31:24], other bits 0.
- `m_sel_o`  out  4  always 4'b1000.
- `m_ack_i`  in  1  slave ack.
- `m_dat_i`  in  32  read data; status byte in [31:24], with bit 25 = rx_empty and bit 24 = ss.

## Operation
**Bus cycle**
- A bus access raises `m_cyc_o`/`m_stb_o` with `m_adr_o`, `m_we_o` and `m_dat_o` stable.
- The controller drops all three strobes on the clock edge at which `m_ack_i` is sampled high.
- `m_dat_i` is captured on that same edge.
- There is never more than one access outstanding.

**Registers and counters**
- `addr` and `len` are latched on `start`.
- `rem` (16-bit) holds the bytes still to request.
- `k` (7-bit) counts the bytes of the current burst.

**States**
- **IDLE**
  - `start` with `len`==0: `done` pulses next cycle, with no bus activity.
  - `start` with `len`≠0: go to SS_ON.
- **SS_ON**: write adr 1, data[24]=0, which asserts SS. Then go to HDR.
- **HDR**: four writes to adr 0, in order: `CMD`, addr[23:16], addr[15:8], addr[7:0]. Then go to DISC.
- **DISC**: repeat 4 times:
  - Poll: read adr 1 until `m_dat_i`[25]==0.
  - Read adr 0 and discard the byte.
  - Then go to FILL.
- **FILL**
  - Set `k` = min(`CHUNK`, `rem`).
  - Write `k` bytes of 8'h00 to adr 0.
  - Subtract `k` from `rem`, then go to POLL.
- **POLL**: read adr 1. If bit 25 is 1, stay in POLL and issue a new read. If bit 25 is 0, go to RD.
- **RD**
  - Read adr 0.
  - Load `out_data` and raise `out_valid`, then go to OUT.
- **OUT**
  - Wait for `out_ready`, then decrement `k`.
  - If `k`≠0, go to POLL.
  - Else if `rem`≠0, go to FILL.
  - Else go to SS_OFF.
  - No bus access is issued while `out_valid` is high.
- **SS_OFF**: write adr 1, data[24]=1. Then pulse `done`, drop `busy` and return to IDLE.

**Other rules**
- `start` while `busy` is ignored.
- The TX FIFO is never overfilled because at most `CHUNK` bytes are outstanding. The RX FIFO is never read while empty.
- Counter widths cover `len` up to 65535. There is no address wrap handling; the flash itself wraps.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `m_cyc_o`=`m_stb_o`=`m_we_o`=0, `m_adr_o`=0, `m_dat_o`=0, `m_sel_o`=4'b1000.
- Against `wb_spi`, which acks one cycle after `stb`, each access takes exactly 2 cycles of `stb`, followed by at least 1 idle cycle.
- The first `m_stb_o` rises 1 cycle after `start` is accepted.
- Between the OUT handshake and the next `m_stb_o` there are at most 1 idle cycle.
- Reset mid-transfer:
  - Synchronously returns all state and outputs to reset values on the next edge, with no SS_OFF write.
  - The `wb_spi` shares `rst_i`, so SS goes high there.
- A `done` pulse is never coincident with `out_valid`.

## Test plan
- Reset with `len`=0: `start` gives `done` high exactly 1 cycle later, `busy` never high, and zero bus accesses.
- `addr`=24'h123456, `len`=1: bus write sequence adr1:0x00, then adr0:0x03,0x12,0x34,0x56, then 4 discard reads, one 0x00 write, one data read, then adr1:0x01. The flash model returns 0xA5, so `out_data`=0xA5.
- `len`=40 with `CHUNK`=16: FILL bursts of 16, 16 and 8. `out` bytes match the model pattern (addr+i)&0xFF for i=0..39. The TX FIFO occupancy never exceeds 16.
- Slow SPI, with rx_empty held 1 for 20 status polls: the controller keeps polling, never reads adr 0 while empty, and the data is intact.
- Backpressure: `out_ready` low for 50 cycles with `out_valid` high: no bus activity, and `out_data` is stable for the whole window.
- `rst_i` asserted in FILL, then deasserted: all outputs at reset values the next cycle, SS high, and a fresh `start` with `len`=2 completes correctly.

Source files
------------

// File: rtl/spi_flash_reader.sv
// Wishbone master that runs an SPI-flash READ through wb_spi: SS on, command and address,
// header discard, chunked dummy-byte fill and readback streamed out on valid/ready, SS off.
module spi_flash_reader #(
    parameter int unsigned CHUNK = 16,
    parameter logic [7:0]  CMD   = 8'h03
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [1:0]  m_adr_o,
    output logic        m_we_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_SS_ON, S_HDR, S_DISC, S_FILL, S_POLL, S_RD, S_OUT, S_SS_OFF
    } state_t;

    localparam logic [15:0] CHUNK_W = 16'(CHUNK);
    localparam logic [6:0]  CHUNK_K = 7'(CHUNK);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [6:0]  k_q, k_d;
    logic [6:0]  idx_q, idx_d;
    logic        phase_q, phase_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [1:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;

    logic        ack_ok;
    logic        bus_state;
    logic        issue;
    logic        fill_last;
    logic [6:0]  chunk_sz;
    logic        req_we;
    logic [1:0]  req_adr;
    logic [7:0]  req_dat;
    logic        unused_dat;

    assign ack_ok     = cyc_q & m_ack_i;
    assign chunk_sz   = (rem_q > CHUNK_W) ? CHUNK_K : rem_q[6:0];
    assign fill_last  = (idx_q + 7'd1) == k_q;
    assign bus_state  = (state_q != S_IDLE) && (state_q != S_OUT);
    // A new access goes out on the cycle after the previous ack, leaving one idle cycle.
    assign issue      = bus_state && !cyc_q;
    assign unused_dat = ^m_dat_i[23:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && len != 16'd0) state_d = S_SS_ON;
            S_SS_ON:  if (ack_ok) state_d = S_HDR;
            S_HDR:    if (ack_ok && idx_q == 7'd3) state_d = S_DISC;
            S_DISC:   if (ack_ok && phase_q && idx_q == 7'd3) state_d = S_FILL;
            S_FILL:   if (ack_ok && fill_last) state_d = S_POLL;
            S_POLL:   if (ack_ok && !m_dat_i[25]) state_d = S_RD;
            S_RD:     if (ack_ok) state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    if (k_q != 7'd1)         state_d = S_POLL;
                    else if (rem_q != 16'd0) state_d = S_FILL;
                    else                     state_d = S_SS_OFF;
                end
            end
            S_SS_OFF: if (ack_ok) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_we  = 1'b0;
        req_adr = 2'd0;
        req_dat = 8'h00;
        case (state_q)
            S_SS_ON:  begin req_we = 1'b1; req_adr = 2'd1; end
            S_HDR: begin
                req_we = 1'b1;
                case (idx_q[1:0])
                    2'd0:    req_dat = CMD;
                    2'd1:    req_dat = addr_q[23:16];
                    2'd2:    req_dat = addr_q[15:8];
                    default: req_dat = addr_q[7:0];
                endcase
            end
            S_DISC:   req_adr = phase_q ? 2'd0 : 2'd1;
            S_FILL:   req_we = 1'b1;
            S_POLL:   req_adr = 2'd1;
            S_SS_OFF: begin req_we = 1'b1; req_adr = 2'd1; req_dat = 8'h01; end
            default:  ;
        endcase

        addr_d      = addr_q;
        rem_d       = rem_q;
        k_d         = k_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;

        if (state_q == S_IDLE && start) begin
            addr_d  = addr;
            rem_d   = len;
            idx_d   = 7'd0;
            phase_d = 1'b0;
            if (len == 16'd0) done_d = 1'b1;
            else              busy_d = 1'b1;
        end

        if (issue) begin
            cyc_d = 1'b1;
            we_d  = req_we;
            adr_d = req_adr;
            dat_d = req_dat;
        end

        if (ack_ok) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            case (state_q)
                S_HDR: idx_d = (idx_q == 7'd3) ? 7'd0 : idx_q + 7'd1;
                S_DISC: begin
                    if (!phase_q) begin
                        if (!m_dat_i[25]) phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (idx_q == 7'd3) begin
                            idx_d = 7'd0;
                            k_d   = chunk_sz;
                            rem_d = rem_q - {9'd0, chunk_sz};
                        end else begin
                            idx_d = idx_q + 7'd1;
                        end
                    end
                end
                S_FILL: idx_d = fill_last ? 7'd0 : idx_q + 7'd1;
                S_RD: begin
                    out_data_d  = m_dat_i[31:24];
                    out_valid_d = 1'b1;
                end
                S_SS_OFF: begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (state_q == S_OUT && out_ready) begin
            out_valid_d = 1'b0;
            k_d         = k_q - 7'd1;
            if (k_q == 7'd1 && rem_q != 16'd0) begin
                k_d   = chunk_sz;
                rem_d = rem_q - {9'd0, chunk_sz};
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;
    assign m_we_o    = we_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = {dat_q, 24'h000000};
    assign m_sel_o   = 4'b1000;

endmodule
